// File: rtl/mfcc_melbank_pkg.sv
// Shared definitions for the MFCC mel-filterbank coefficient path.
//   - loader FSM state encoding
//   - bytes_per_word(): number of bytes needed to build one coefficient word
//   - default RAM geometry, shared with the coefficient RAM instance
package mfcc_melbank_pkg;

  localparam int unsigned MELBANK_ADDR_WIDTH = 4;
  localparam int unsigned MELBANK_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/mfcc_byte_packer.sv
// Packs an LSB-first byte stream into DATA_WIDTH-bit words.
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   clear_i        synchronous restart of the byte index
//   accept_i       a byte is being accepted this cycle
//   byte_i         incoming byte
//   word_done_o    combinational: the accepted byte completes a word
//   word_o         combinational: completed word (valid with word_done_o)
module mfcc_byte_packer
  import mfcc_melbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MELBANK_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [7:0]            byte_i,
  output logic                  word_done_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int unsigned BPW   = bytes_per_word(DATA_WIDTH);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BPW*8-1:0] word_full;

  assign word_done_o = accept_i && (idx_q == LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      idx_d = word_done_o ? '0 : idx_q + IDX_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  generate
    if (BPW == 1) begin : g_single
      assign word_full = byte_i;
    end else begin : g_multi
      // Only the lower BPW-1 lanes are stored; the top lane comes straight
      // from the completing byte so the word is ready on the same edge.
      // Stale lanes after a clear are harmless: every lane is rewritten
      // before the next word can complete.
      logic [(BPW-1)*8-1:0] lanes_q, lanes_d;

      always_comb begin
        lanes_d = lanes_q;
        if (accept_i && !word_done_o) begin
          for (int unsigned i = 0; i < BPW - 1; i++) begin
            if (idx_q == IDX_W'(i)) begin
              lanes_d[i*8 +: 8] = byte_i;
            end
          end
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          lanes_q <= '0;
        end else begin
          lanes_q <= lanes_d;
        end
      end

      assign word_full = {byte_i, lanes_q};
    end
  endgenerate

  assign word_o = word_full[DATA_WIDTH-1:0];

endmodule

// File: rtl/mfcc_melbank_coef_loader.sv
// Write-side loader for the mel-filterbank coefficient RAM.
// Takes a valid/ready byte stream, packs bytes LSB-first into DATA_WIDTH-bit
// words and writes DEPTH words to sequential addresses starting at BASE_ADDR
// (wrapping modulo 2**ADDR_WIDTH). Reports done, a mod-256 byte checksum and
// the number of words written.
// Ports:
//   wr_clk, asyn_rst          RAM write clock, asynchronous active-high reset
//   start, abort              load request (IDLE only) / cancel (any state)
//   in_byte, in_valid         byte stream in
//   in_ready                  high while loading (combinational on state)
//   ram_wr_en/addr/data       registered RAM write port
//   busy, done, aborted       status: loading/flushing, completion pulse,
//                             sticky cancel flag
//   checksum, words_loaded    load statistics
module mfcc_melbank_coef_loader
  import mfcc_melbank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MELBANK_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MELBANK_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  wr_clk,
  input  logic                  asyn_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [7:0]            checksum,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH:0]   LAST_WORD = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   WORD_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  loader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ram_wr_en_q;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q;
  logic [DATA_WIDTH-1:0] ram_wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;
  logic [7:0]            checksum_q;
  logic [ADDR_WIDTH:0]   words_q;

  logic                  accept;
  logic                  pack_clear;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] packed_word;

  assign in_ready = (state_q == ST_LOAD);
  assign accept   = in_valid && in_ready;

  // The byte index only matters in LOAD, so holding it clear everywhere
  // else covers both the restart on start and the discard on abort.
  assign pack_clear = abort || (state_q != ST_LOAD);

  mfcc_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk_i       (wr_clk),
    .rst_i       (asyn_rst),
    .clear_i     (pack_clear),
    .accept_i    (accept && !abort),
    .byte_i      (in_byte),
    .word_done_o (word_done),
    .word_o      (packed_word)
  );

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      checksum_q    <= '0;
      words_q       <= '0;
    end else begin
      ram_wr_en_q <= 1'b0;
      if (abort) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q    <= ST_LOAD;
              busy_q     <= 1'b1;
              aborted_q  <= 1'b0;
              checksum_q <= '0;
              words_q    <= '0;
              addr_q     <= BASE;
            end
          end
          ST_LOAD: begin
            if (accept) begin
              checksum_q <= checksum_q + in_byte;
              if (word_done) begin
                ram_wr_en_q   <= 1'b1;
                ram_wr_addr_q <= addr_q;
                ram_wr_data_q <= packed_word;
                addr_q        <= addr_q + ADDR_ONE;
                words_q       <= words_q + WORD_ONE;
                if (words_q == LAST_WORD) begin
                  state_q <= ST_FLUSH;
                end
              end
            end
          end
          ST_FLUSH: begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign ram_wr_en    = ram_wr_en_q;
  assign ram_wr_addr  = ram_wr_addr_q;
  assign ram_wr_data  = ram_wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign checksum     = checksum_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_mfcc_melbank_coef_loader.sv
// Scoreboard bench for mfcc_melbank_coef_loader, configured with a 12-bit word
// (two bytes per word, top nibble dropped), DEPTH=4 and BASE_ADDR=14 so the
// address wraps through 0.
module tb_mfcc_melbank_coef_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BASE  = 14;
  localparam int unsigned BPW   = (DW + 7) / 8;

  logic          wr_clk = 1'b0;
  logic          asyn_rst;
  logic          start, abort, in_valid;
  logic [7:0]    in_byte;
  logic          in_ready, ram_wr_en, busy, done, aborted;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [7:0]    checksum;
  logic [AW:0]   words_loaded;

  always #5 wr_clk = ~wr_clk;

  mfcc_melbank_coef_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .wr_clk       (wr_clk),
    .asyn_rst     (asyn_rst),
    .start        (start),
    .abort        (abort),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .checksum     (checksum),
    .words_loaded (words_loaded)
  );

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  cks;
    logic [AW:0] words;
  } dn_t;

  wr_t exp_wr[$];
  dn_t exp_done[$];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  // Reference model: what the loader should be doing after the latest edge.
  logic        m_loading = 1'b0;
  int unsigned m_tail    = 0;   // 2: final write on the port, 1: done showing
  logic        m_aborted = 1'b0;
  logic [7:0]  m_cksum   = '0;
  int unsigned m_words   = 0;
  logic [7:0]  m_bytes[$];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes/done pulses when the DUT presents them.
  always @(negedge wr_clk) begin : monitor
    wr_t w;
    dn_t d;
    if (!asyn_rst) begin
      while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
        w = exp_wr.pop_front();
        checks++; errors++;
        $display("FAIL missed_write: no write seen, expected addr 0x%0h data 0x%0h at cycle %0d", w.addr, w.data, w.cyc);
      end
      while (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
        d = exp_done.pop_front();
        checks++; errors++;
        $display("FAIL missed_done: no done seen, expected at cycle %0d", d.cyc);
      end
      if (ram_wr_en === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)", ram_wr_addr, ram_wr_data, cyc);
        end else begin
          w = exp_wr.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_addr", 32'(ram_wr_addr), 32'(w.addr));
          check("wr_data", 32'(ram_wr_data), 32'(w.data));
          last_addr = w.addr;
          last_data = w.data;
        end
      end else begin
        check("wr_en", 32'(ram_wr_en), 32'd0);
        check("wr_addr_hold", 32'(ram_wr_addr), 32'(last_addr));
        check("wr_data_hold", 32'(ram_wr_data), 32'(last_data));
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
        end else begin
          d = exp_done.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("done_checksum", 32'(checksum), 32'(d.cks));
          check("done_words", 32'(words_loaded), 32'(d.words));
        end
      end
    end
  end

  // One clock of stimulus: check the current status outputs against the
  // model, drive inputs, advance the model across the coming edge.
  task automatic step(input logic s, input logic a, input logic v, input logic [7:0] b);
    int unsigned e;
    longint      acc;
    wr_t         w;
    dn_t         d;
    check("in_ready", 32'(in_ready), 32'(m_loading));
    check("busy", 32'(busy), 32'(m_loading || m_tail == 2));
    check("aborted", 32'(aborted), 32'(m_aborted));
    check("checksum", 32'(checksum), 32'(m_cksum));
    check("words_loaded", 32'(words_loaded), m_words);
    start = s; abort = a; in_valid = v; in_byte = b;
    e = cyc + 1;
    if (a) begin
      if (m_tail == 2) void'(exp_done.pop_back());
      m_loading = 1'b0;
      m_tail    = 0;
      m_aborted = 1'b1;
      m_bytes.delete();
    end else if (m_loading) begin
      if (v) begin
        m_bytes.push_back(b);
        m_cksum = m_cksum + b;
        if (m_bytes.size() == BPW) begin
          acc = 0;
          for (int unsigned k = 0; k < BPW; k++)
            acc = acc + longint'(m_bytes[k]) * (longint'(1) << (8 * k));
          w.cyc  = e;
          w.addr = AW'((BASE + m_words) % (1 << AW));
          w.data = DW'(acc % (longint'(1) << DW));
          exp_wr.push_back(w);
          m_words++;
          m_bytes.delete();
          if (m_words == DEPTH) begin
            m_loading = 1'b0;
            m_tail    = 2;
            d.cyc   = e + 1;
            d.cks   = m_cksum;
            d.words = (AW + 1)'(m_words);
            exp_done.push_back(d);
          end
        end
      end
    end else if (m_tail > 0) begin
      m_tail--;
    end else if (s) begin
      m_loading = 1'b1;
      m_aborted = 1'b0;
      m_cksum   = '0;
      m_words   = 0;
      m_bytes.delete();
    end
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    check("rst_wr_data", 32'(ram_wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
  endtask

  // Asynchronous reset between edges; called only mid-word, so no write or
  // done is due in the current cycle.
  task automatic pulse_reset();
    #1 asyn_rst = 1'b1;
    #1;
    check_reset_values();
    asyn_rst  = 1'b0;
    m_loading = 1'b0;
    m_tail    = 0;
    m_aborted = 1'b0;
    m_cksum   = '0;
    m_words   = 0;
    m_bytes.delete();
    exp_done.delete();
    last_addr = '0;
    last_data = '0;
  endtask

  logic [7:0] tbl_a[8] = '{8'hAB, 8'hFC, 8'h34, 8'h12, 8'h78, 8'h56, 8'h01, 8'h02};

  initial begin
    asyn_rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_byte = '0;
    repeat (2) @(posedge wr_clk);
    #1;
    check_reset_values();
    asyn_rst = 1'b0;
    step(0, 0, 0, 8'h00);

    // Back-to-back load through the address wrap; start during FLUSH/DONE.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, tbl_a[i]);
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("cks_directed", 32'(checksum), 32'hBE);
    step(0, 0, 0, 8'h00);

    // Valid toggling 1,0,1,0 with a start pulse in the middle of LOAD.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++)
      step(i == 5, 0, (i % 2) == 0, 8'(8'h10 + i));
    repeat (3) step(0, 0, 0, 8'h00);

    // Abort after three bytes, then a fresh load from BASE.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'hC0 + i));
    step(0, 1, 0, 8'h00);
    repeat (2) step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h21 * i));
    repeat (3) step(0, 0, 0, 8'h00);

    // Abort together with start in IDLE: no load begins.
    step(1, 1, 0, 8'h00);
    repeat (2) step(0, 0, 1, 8'h77);

    // Abort on the word-completing byte: write suppressed.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h11);
    step(0, 1, 1, 8'h22);
    repeat (2) step(0, 0, 0, 8'h00);

    // Asynchronous reset in the middle of a word.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h5A);
    pulse_reset();
    repeat (2) step(0, 0, 1, 8'h66);

    // Randomised loads with gaps, stray starts and rare aborts.
    for (int unsigned l = 0; l < 30; l++) begin
      step(1, 0, 0, 8'h00);
      for (int unsigned k = 0; k < 200 && (m_loading || m_tail > 0); k++)
        step($urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0,
             $urandom_range(0, 9) < 7, 8'($urandom));
      step(0, 0, 0, 8'h00);
    end

    repeat (3) step(0, 0, 0, 8'h00);
    check("pending_writes", exp_wr.size(), 32'd0);
    check("pending_done", exp_done.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
